// File: rtl/qspi_flash_rd_arb.sv
// Two-port round-robin read sequencer for a quad-SPI flash (Fast Read Quad I/O, EBh).
// SCK runs at HCLK/2; every flash-side output is registered and changes on the SCK falling edge.
module qspi_flash_rd_arb #(
    parameter int          DUMMY   = 4,
    parameter logic [7:0]  MODE    = 8'hA0,
    parameter int          CSH_CYC = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  req,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [31:0] rdata,
    input  logic [3:0]  fdi,
    output logic [3:0]  fdo,
    output logic        fdoe,
    output logic        fsclk,
    output logic        fcen
);

    localparam logic [7:0] CMD_EB = 8'hEB;
    localparam int         CW     = $clog2(CSH_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA, ST_DONE, ST_CSH
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [CW-1:0]  csh_q, csh_d;
    logic           sel_q, sel_d;
    logic           rr_last_q, rr_last_d;
    logic [23:0]    addr_q, addr_d;
    logic [31:0]    rx_q, rx_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [1:0]     done_q, done_d;
    logic           fsclk_q, fsclk_d;
    logic           fcen_q, fcen_d;
    logic           fdoe_q, fdoe_d;
    logic [3:0]     fdo_q, fdo_d;

    logic           win;
    logic           last;
    logic [2:0]     idx;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            csh_q     <= '0;
            sel_q     <= 1'b0;
            rr_last_q <= 1'b1;
            addr_q    <= 24'd0;
            rx_q      <= 32'd0;
            rdata_q   <= 32'd0;
            done_q    <= 2'b00;
            fsclk_q   <= 1'b0;
            fcen_q    <= 1'b1;
            fdoe_q    <= 1'b0;
            fdo_q     <= 4'hF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            csh_q     <= csh_d;
            sel_q     <= sel_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            fsclk_q   <= fsclk_d;
            fcen_q    <= fcen_d;
            fdoe_q    <= fdoe_d;
            fdo_q     <= fdo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        csh_d     = csh_q;
        sel_d     = sel_q;
        rr_last_d = rr_last_q;
        addr_d    = addr_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        done_d    = 2'b00;
        fsclk_d   = fsclk_q;
        fcen_d    = fcen_q;
        fdoe_d    = fdoe_q;
        fdo_d     = fdo_q;
        gnt       = 2'b00;
        win       = 1'b0;
        // cnt counts remaining SCKs in the state; idx picks the next bit/nibble to shift out
        last      = (cnt_q == 4'd0);
        idx       = cnt_q[2:0] - 3'd1;

        case (state_q)
            ST_IDLE: begin
                // HRESETn gate keeps the combinational grant quiet while held in reset
                if (HRESETn && (req != 2'b00)) begin
                    win       = (req == 2'b11) ? ~rr_last_q : req[1];
                    gnt       = win ? 2'b10 : 2'b01;
                    sel_d     = win;
                    rr_last_d = win;
                    addr_d    = win ? addr1 : addr0;
                    state_d   = ST_CMD;
                    cnt_d     = 4'd7;
                    fcen_d    = 1'b0;
                    fdoe_d    = 1'b1;
                    fdo_d     = {3'b111, CMD_EB[7]};
                end
            end
            ST_DONE: begin
                fcen_d  = 1'b1;
                fsclk_d = 1'b0;
                done_d  = sel_q ? 2'b10 : 2'b01;
                rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                state_d = ST_CSH;
                csh_d   = CW'(CSH_CYC - 1);
            end
            ST_CSH: begin
                if (csh_q == '0) state_d = ST_IDLE;
                else             csh_d   = csh_q - CW'(1);
            end
            default: begin
                if (!fsclk_q) begin
                    fsclk_d = 1'b1;
                end else begin
                    // falling SCK edge: sample fdi, shift the next output, step the counter
                    fsclk_d = 1'b0;
                    cnt_d   = cnt_q - 4'd1;
                    case (state_q)
                        ST_CMD: begin
                            if (!last) fdo_d = {3'b111, CMD_EB[idx]};
                            else begin
                                state_d = ST_ADDR;
                                cnt_d   = 4'd5;
                                fdo_d   = addr_q[23:20];
                            end
                        end
                        ST_ADDR: begin
                            if (!last) fdo_d = 4'(addr_q >> {idx, 2'b00});
                            else begin
                                state_d = ST_MODE;
                                cnt_d   = 4'd1;
                                fdo_d   = MODE[7:4];
                            end
                        end
                        ST_MODE: begin
                            if (!last) fdo_d = MODE[3:0];
                            else begin
                                state_d = ST_DUMMY;
                                cnt_d   = 4'(DUMMY - 1);
                                fdoe_d  = 1'b0;
                                fdo_d   = 4'hF;
                            end
                        end
                        ST_DUMMY: begin
                            if (last) begin
                                state_d = ST_DATA;
                                cnt_d   = 4'd7;
                            end
                        end
                        ST_DATA: begin
                            rx_d = {rx_q[27:0], fdi};
                            if (last) state_d = ST_DONE;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    assign done  = done_q;
    assign rdata = rdata_q;
    assign fdo   = fdo_q;
    assign fdoe  = fdoe_q;
    assign fsclk = fsclk_q;
    assign fcen  = fcen_q;

endmodule

// File: tb/tb_qspi_flash_rd_arb.sv
// Directed bench for qspi_flash_rd_arb with a behavioural EBh quad-read flash model.
module tb_qspi_flash_rd_arb;

    localparam int DUMMY   = 4;
    localparam int CSH_CYC = 4;
    localparam int LAT     = 2 * (24 + DUMMY) + 2;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [23:0] addr0 = 24'd0;
    logic [23:0] addr1 = 24'd0;
    logic [1:0]  gnt, done;
    logic [31:0] rdata;
    logic [3:0]  fdi = 4'h0;
    logic [3:0]  fdo;
    logic        fdoe, fsclk, fcen;

    always #5 HCLK = ~HCLK;

    qspi_flash_rd_arb #(.DUMMY(DUMMY), .MODE(8'hA0), .CSH_CYC(CSH_CYC)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .addr0(addr0), .addr1(addr1),
        .gnt(gnt), .done(done), .rdata(rdata), .fdi(fdi), .fdo(fdo),
        .fdoe(fdoe), .fsclk(fsclk), .fcen(fcen)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {mem_rd(a + 24'd3), mem_rd(a + 24'd2), mem_rd(a + 24'd1), mem_rd(a)};
    endfunction

    // flash model: shifts in on rising SCK, drives data nibbles on falling SCK
    int          sck_n = 0;
    int          oe_bad = 0;
    int          k;
    logic [7:0]  b;
    logic [7:0]  f_cmd = 8'd0, f_mode = 8'd0;
    logic [23:0] f_addr = 24'd0;

    always @(negedge fcen) sck_n = 0;

    always @(posedge fsclk) if (!fcen) begin
        if (sck_n < 8) begin
            f_cmd = {f_cmd[6:0], fdo[0]};
            if (!fdoe || fdo[3:1] != 3'b111) oe_bad++;
        end else if (sck_n < 14) begin
            f_addr = {f_addr[19:0], fdo};
            if (!fdoe) oe_bad++;
        end else if (sck_n < 16) begin
            f_mode = {f_mode[3:0], fdo};
            if (!fdoe) oe_bad++;
        end else if (fdoe) oe_bad++;
        sck_n++;
    end

    always @(negedge fsclk) if (!fcen && sck_n >= 16 + DUMMY) begin
        k   = sck_n - 16 - DUMMY;
        b   = mem_rd(f_addr + 24'(k / 2));
        fdi = k[0] ? b[3:0] : b[7:4];
    end

    // event monitor, sampled on the falling HCLK edge
    int          cyc = 0;
    int          gq_cyc[$];
    logic [1:0]  gq_val[$];
    int          dq_cyc[$];
    logic [1:0]  dq_val[$];
    logic [31:0] dq_dat[$];
    int          hi_cnt = 0, min_gap = 1000, sck_bad = 0;
    bit          seen = 1'b0;

    always @(posedge HCLK) cyc++;

    always @(negedge HCLK) begin
        if (gnt != 2'b00) begin gq_cyc.push_back(cyc); gq_val.push_back(gnt); end
        if (done != 2'b00) begin dq_cyc.push_back(cyc); dq_val.push_back(done); dq_dat.push_back(rdata); end
        if (fcen && fsclk) sck_bad++;
        if (fcen) hi_cnt++;
        else begin
            if (seen && hi_cnt > 0 && hi_cnt < min_gap) min_gap = hi_cnt;
            seen   = 1'b1;
            hi_cnt = 0;
        end
    end

    task automatic wait_done(input int n, input int budget);
        int i = 0;
        while (dq_cyc.size() < n && i < budget) begin @(negedge HCLK); i++; end
        if (dq_cyc.size() < n) chk("wait_done", dq_cyc.size(), n);
    endtask

    task automatic wait_gnt(input int n, input int budget);
        int i = 0;
        while (gq_cyc.size() < n && i < budget) begin @(negedge HCLK); i++; end
        if (gq_cyc.size() < n) chk("wait_gnt", gq_cyc.size(), n);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    int bg, bd, i;

    initial begin
        // reset state, with a request already pending
        tick(2);
        req   = 2'b01;
        addr0 = 24'h000100;
        @(negedge HCLK);
        chk("rst_fcen", fcen, 1'b1);
        chk("rst_fsclk", fsclk, 1'b0);
        chk("rst_fdoe", fdoe, 1'b0);
        chk("rst_fdo", fdo, 4'hF);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_rdata", rdata, 32'd0);
        tick(1);
        HRESETn = 1'b1;

        // single port-0 read with preloaded 11 22 33 44
        wait_done(1, 200);
        chk("t1_gnt", gq_val[0], 2'b01);
        chk("t1_lat", dq_cyc[0] - gq_cyc[0], LAT);
        chk("t1_port", dq_val[0], 2'b01);
        chk("t1_data", dq_dat[0], 32'h44332211);
        chk("t1_cmd", f_cmd, 8'hEB);
        chk("t1_addr", f_addr, 24'h000100);
        chk("t1_mode", f_mode, 8'hA0);
        tick(1);
        req = 2'b00;

        // request withdrawn right after grant, wrapping address
        tick(10);
        req   = 2'b01;
        addr0 = 24'hFFFFFE;
        wait_gnt(2, 50);
        tick(1);
        req = 2'b00;
        wait_done(2, 200);
        chk("t6_lat", dq_cyc[1] - gq_cyc[1], LAT);
        chk("t6_port", dq_val[1], 2'b01);
        chk("t6_data", dq_dat[1], exp_word(24'hFFFFFE));
        tick(80);
        chk("t6_noregrant", gq_cyc.size(), 2);

        // reset during the data phase aborts without done
        req   = 2'b01;
        addr0 = 24'h000400;
        wait_gnt(3, 50);
        tick(1);
        i = 0;
        while (sck_n < 16 + DUMMY + 3 && i < 200) begin @(negedge HCLK); i++; end
        chk("t5_reach_data", (sck_n >= 16 + DUMMY + 3), 1'b1);
        tick(1);
        HRESETn = 1'b0;
        req     = 2'b00;
        #1;
        chk("t5_fcen", fcen, 1'b1);
        chk("t5_fsclk", fsclk, 1'b0);
        chk("t5_fdoe", fdoe, 1'b0);
        tick(3);
        HRESETn = 1'b1;
        tick(80);
        chk("t5_nodone", dq_cyc.size(), 2);

        // both ports held: grants alternate starting with port 0
        bg    = gq_cyc.size();
        bd    = dq_cyc.size();
        addr0 = 24'h000200;
        addr1 = 24'h0003F0;
        req   = 2'b11;
        wait_done(bd + 4, 400);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t2_gnt%0d", j), gq_val[bg + j], (j % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("t2_port%0d", j), dq_val[bd + j], (j % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("t2_data%0d", j), dq_dat[bd + j],
                exp_word((j % 2 == 0) ? 24'h000200 : 24'h0003F0));
            chk($sformatf("t2_lat%0d", j), dq_cyc[bd + j] - gq_cyc[bg + j], LAT);
            if (j > 0)
                chk($sformatf("t2_space%0d", j), gq_cyc[bg + j] - gq_cyc[bg + j - 1], LAT + CSH_CYC);
        end
        chk("t2_cmd", f_cmd, 8'hEB);
        chk("t2_addr", f_addr, 24'h0003F0);
        tick(1);
        req = 2'b00;

        // port 0 arrives mid-transaction of port 1
        tick(5);
        bg    = gq_cyc.size();
        bd    = dq_cyc.size();
        addr1 = 24'h000500;
        req   = 2'b10;
        wait_gnt(bg + 1, 50);
        tick(20);
        addr0 = 24'h000600;
        req   = 2'b11;
        wait_done(bd + 1, 200);
        tick(1);
        req = 2'b01;
        wait_done(bd + 2, 200);
        chk("t3_gnt1", gq_val[bg], 2'b10);
        chk("t3_data1", dq_dat[bd], exp_word(24'h000500));
        chk("t3_gnt0", gq_val[bg + 1], 2'b01);
        chk("t3_port0", dq_val[bd + 1], 2'b01);
        chk("t3_data0", dq_dat[bd + 1], exp_word(24'h000600));
        chk("t3_space", gq_cyc[bg + 1] - gq_cyc[bg], LAT + CSH_CYC);
        tick(1);
        req = 2'b00;
        tick(10);

        chk("csh_min_ok", (min_gap >= CSH_CYC), 1'b1);
        chk("fdoe_phases", oe_bad, 0);
        chk("sck_idle_low", sck_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d want=0", 1);
        $fatal(1, "timeout");
    end

endmodule
